// File: rtl/pc16_sequencer_pkg.sv
// Shared definitions for the pc16_sequencer program-counter stage:
// default address width, the per-edge action encodings produced by the
// command priority encoder, the reset value, and the encoder itself.
package pc16_sequencer_pkg;

    localparam int PC16_WIDTH       = 16;
    localparam int PC16_RESET_VALUE = 0;

    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_INC  = 3'd1,
        ACT_LOAD = 3'd2,
        ACT_CALL = 3'd3,
        ACT_RET  = 3'd4,
        ACT_CLR  = 3'd5
    } pc16_action_e;

    // Exactly one action per edge: clr > ret > call > load > inc > hold.
    function automatic pc16_action_e pc16_select_action(
        input logic clr,
        input logic ret,
        input logic call,
        input logic load,
        input logic inc
    );
        if (clr)       return ACT_CLR;
        else if (ret)  return ACT_RET;
        else if (call) return ACT_CALL;
        else if (load) return ACT_LOAD;
        else if (inc)  return ACT_INC;
        else           return ACT_HOLD;
    endfunction

endpackage

// File: rtl/pc16_ras.sv
// Return-address stack for pc16_sequencer: a circular LIFO of
// DEPTH x WIDTH entries. A push onto a full stack overwrites the oldest
// entry, so the stack always holds the most recent DEPTH return addresses.
// Only instantiated when PC16_RAS_EN is defined.
module pc16_ras
    import pc16_sequencer_pkg::*;
#(
    parameter int WIDTH = PC16_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign top   = mem[wr_ptr - PTR_W'(1)];

    // Write pointer wraps naturally (DEPTH is a power of two); count saturates at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= PTR_W'(PC16_RESET_VALUE);
            count  <= CNT_W'(PC16_RESET_VALUE);
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            count  <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset; an empty stack never exposes its contents.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc16_sequencer.sv
// Program-counter stage: registers the upstream selector's jump target and
// produces the instruction address with hold / increment / load / clear.
// Build option: define PC16_RAS_EN to add the return-address stack that
// gives call/return sequencing. Without it, call acts as load and ret is
// ignored, and the ras_* outputs are constant.
module pc16_sequencer
    import pc16_sequencer_pkg::*;
#(
    parameter int WIDTH     = PC16_WIDTH,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             clr,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc16_sequencer: RAS_DEPTH must be a power of two and at least 2");
    end

`ifdef PC16_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    pc16_action_e     action;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH-1:0] out_next;
    logic             wrap_next;
    logic             err_next;
    logic             stack_empty;

`ifdef PC16_RAS_EN
    logic             ras_push;
    logic             ras_pop;
    logic [WIDTH-1:0] ras_top;
    logic             stack_full;

    pc16_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (inc_sum[WIDTH-1:0]),
        .top       (ras_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign ras_empty = stack_empty;
    assign ras_full  = stack_full;
`else
    assign stack_empty = 1'b1;
    assign ras_empty   = 1'b1;
    assign ras_full    = 1'b0;
`endif

    assign inc_sum = {1'b0, out} + (WIDTH + 1)'(1);

    // Pick the single action for this edge; ret is dead without the stack.
    always_comb begin
        action = pc16_select_action(clr, ret && RAS_ON, call, load, inc);
    end

    // Next program counter, pulse flags and stack strobes for the chosen action.
    always_comb begin
        out_next  = out;
        wrap_next = 1'b0;
        err_next  = 1'b0;
`ifdef PC16_RAS_EN
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
`endif
        case (action)
            ACT_CLR: begin
                out_next = WIDTH'(PC16_RESET_VALUE);
            end
`ifdef PC16_RAS_EN
            ACT_RET: begin
                if (!stack_empty) begin
                    out_next = ras_top;
                    ras_pop  = 1'b1;
                end else begin
                    err_next = 1'b1;
                end
            end
            ACT_CALL: begin
                ras_push = 1'b1;
                out_next = in;
            end
`else
            ACT_CALL: begin
                out_next = in;
            end
`endif
            ACT_LOAD: begin
                out_next = in;
            end
            ACT_INC: begin
                out_next  = inc_sum[WIDTH-1:0];
                wrap_next = inc_sum[WIDTH];
            end
            default: begin
                out_next = out;
            end
        endcase
    end

    // Program counter and one-cycle pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= WIDTH'(PC16_RESET_VALUE);
            wrap    <= 1'b0;
            ras_err <= 1'b0;
        end else begin
            out     <= out_next;
            wrap    <= wrap_next;
            ras_err <= err_next && !stack_empty ? 1'b0 : err_next;
        end
    end

endmodule

// File: tb/tb_pc16_sequencer.sv
// Directed self-checking bench for pc16_sequencer. Covers the stack
// scenarios when PC16_RAS_EN is defined, and the call-as-load behaviour
// otherwise.
module tb_pc16_sequencer;
    import pc16_sequencer_pkg::*;

    localparam int W = PC16_WIDTH;

    logic         clk;
    logic         rst;
    logic [W-1:0] in;
    logic         load;
    logic         inc;
    logic         clr;
    logic         call;
    logic         ret;
    logic [W-1:0] out;
    logic         wrap;
    logic         ras_empty;
    logic         ras_full;
    logic         ras_err;

    int tests_run;
    int tests_failed;

    pc16_sequencer #(
        .WIDTH     (W),
        .RAS_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .load      (load),
        .inc       (inc),
        .clr       (clr),
        .call      (call),
        .ret       (ret),
        .out       (out),
        .wrap      (wrap),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive one command for one edge, then return 1 ns after that edge with controls idle.
    task automatic applyStimulus(input logic [W-1:0] in_v, input logic load_v, input logic inc_v,
                                 input logic clr_v, input logic call_v, input logic ret_v);
        in   = in_v;
        load = load_v;
        inc  = inc_v;
        clr  = clr_v;
        call = call_v;
        ret  = ret_v;
        @(posedge clk);
        #1;
        load = 1'b0;
        inc  = 1'b0;
        clr  = 1'b0;
        call = 1'b0;
        ret  = 1'b0;
    endtask

`ifdef PC16_RAS_EN
    logic [W-1:0] ret_expect [4];
    logic [W-1:0] call_target [5];
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst  = 1'b1;
        in   = '0;
        load = 1'b0;
        inc  = 1'b0;
        clr  = 1'b0;
        call = 1'b0;
        ret  = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        checkOutput("reset_out", 32'(out), 32'h0);
        checkOutput("reset_wrap", 32'(wrap), 32'h0);
        checkOutput("reset_empty", 32'(ras_empty), 32'h1);
        checkOutput("reset_full", 32'(ras_full), 32'h0);
        checkOutput("reset_err", 32'(ras_err), 32'h0);
        rst = 1'b0;

        // Five increments, then an asynchronous reset between edges
        for (int i = 0; i < 5; i++) begin
            applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("inc5_out", 32'(out), 32'h5);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out", 32'(out), 32'h0);
        checkOutput("async_rst_empty", 32'(ras_empty), 32'h1);
        #1;
        rst = 1'b0;

        // Increment wrap pulse
        applyStimulus(16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("load_fffe", 32'(out), 32'hFFFE);
        applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("inc_ffff", 32'(out), 32'hFFFF);
        checkOutput("wrap_before", 32'(wrap), 32'h0);
        applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("inc_wrap_out", 32'(out), 32'h0);
        checkOutput("inc_wrap_flag", 32'(wrap), 32'h1);
        applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("inc_after_wrap", 32'(out), 32'h1);
        checkOutput("wrap_cleared", 32'(wrap), 32'h0);
        applyStimulus(16'h7777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_out", 32'(out), 32'h1);

        // Priority between simultaneous commands
        applyStimulus(16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("load_beats_inc", 32'(out), 32'h1234);
        applyStimulus(16'h5678, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("clr_beats_load", 32'(out), 32'h0);
        applyStimulus(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("load_0001", 32'(out), 32'h1);
        applyStimulus(16'h4321, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_beats_all", 32'(out), 32'h0);
        checkOutput("clr_no_push", 32'(ras_empty), 32'h1);
        checkOutput("clr_no_err", 32'(ras_err), 32'h0);

`ifdef PC16_RAS_EN
        // Nested call / return
        applyStimulus(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("call1_out", 32'(out), 32'h0100);
        checkOutput("call1_empty", 32'(ras_empty), 32'h0);
        applyStimulus(16'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("call2_out", 32'(out), 32'h0200);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ret1_out", 32'(out), 32'h0101);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ret2_out", 32'(out), 32'h0011);
        checkOutput("ret2_empty", 32'(ras_empty), 32'h1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ret_empty_out", 32'(out), 32'h0011);
        checkOutput("ret_empty_err", 32'(ras_err), 32'h1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("err_one_cycle", 32'(ras_err), 32'h0);

        // call+ret: ret wins and the call is dropped
        applyStimulus(16'h0999, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("callret_out", 32'(out), 32'h0011);
        checkOutput("callret_err", 32'(ras_err), 32'h1);
        checkOutput("callret_nopush", 32'(ras_empty), 32'h1);

        // Overflow: five calls into a four-deep stack
        applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        call_target = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000};
        ret_expect  = '{16'h4001, 16'h3001, 16'h2001, 16'h1001};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(call_target[i], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("ovf_call%0d_out", i), 32'(out), 32'(call_target[i]));
            checkOutput($sformatf("ovf_call%0d_full", i), 32'(ras_full), (i >= 3) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("ovf_ret%0d_out", i), 32'(out), 32'(ret_expect[i]));
            checkOutput($sformatf("ovf_ret%0d_err", i), 32'(ras_err), 32'h0);
        end
        checkOutput("ovf_drained", 32'(ras_empty), 32'h1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_ret5_out", 32'(out), 32'h1001);
        checkOutput("ovf_ret5_err", 32'(ras_err), 32'h1);

        // Reset mid-operation empties the stack
        applyStimulus(16'h0AAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_rst_empty", 32'(ras_empty), 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_empty", 32'(ras_empty), 32'h1);
        checkOutput("mid_rst_out", 32'(out), 32'h0);
        #1;
        rst = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("post_rst_ret_err", 32'(ras_err), 32'h1);
`else
        // Without the stack: call acts as load, ret is ignored
        applyStimulus(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h0ABC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("nras_call_out", 32'(out), 32'h0ABC);
        checkOutput("nras_call_empty", 32'(ras_empty), 32'h1);
        checkOutput("nras_call_full", 32'(ras_full), 32'h0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("nras_ret_out", 32'(out), 32'h0ABC);
        checkOutput("nras_ret_err", 32'(ras_err), 32'h0);
        checkOutput("nras_ret_empty", 32'(ras_empty), 32'h1);
        applyStimulus(16'h0DEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("nras_callret_out", 32'(out), 32'h0DEF);
        checkOutput("nras_callret_err", 32'(ras_err), 32'h0);
        applyStimulus(16'h0123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("nras_ret_inc_out", 32'(out), 32'h0DF0);
        applyStimulus(16'h0456, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("nras_call_inc_out", 32'(out), 32'h0456);
        checkOutput("nras_full_end", 32'(ras_full), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/pc16_sequencer.md
Name: pc16_sequencer

Overview:
- Program-counter stage sitting directly downstream of the 16-bit two-input selector in the core datapath.
- The selector's output drives this block's `in` bus as the jump target. This block registers it and produces the instruction address.
- Supports hold, increment, load, and synchronous clear.
- Optional return-address stack provides call/return sequencing.

Parameters:
- WIDTH, 16, address/data width of `in` and `out`.
- RAS_DEPTH, 4, return-address stack entries (used only with PC16_RAS_EN); power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  jump target from upstream 16-bit selector.
- load  input  1  load `in` next edge.
- inc  input  1  increment next edge.
- clr  input  1  synchronous clear to 0.
- call  input  1  push return address, jump to `in` (RAS).
- ret  input  1  pop return address into `out` (RAS).
- out  output  WIDTH  current program counter (registered).
- wrap  output  1  one-cycle pulse: increment wrapped all-ones→0.
- ras_empty  output  1  stack holds no entries.
- ras_full  output  1  stack holds RAS_DEPTH entries.
- ras_err  output  1  one-cycle pulse: `ret` with empty stack.

Behaviour:
- Reset (async, rst=1): out=0, wrap=0, ras_err=0, stack count=0, ras_empty=1, ras_full=0. Takes effect immediately without a clock; outputs stay there while rst=1.
- All state changes on rising clk. `out` updates one cycle after the command is sampled; there is no combinational path from inputs to `out`.
- Command priority per edge: clr > ret > call > load > inc > hold. Exactly one action per edge.
  - clr: out←0; stack untouched.
  - ret:
    - Stack non-empty: out←top, count−1.
    - Stack empty: out holds, ras_err=1 for one cycle.
  - call: push (out+1) mod 2^WIDTH, then out←in.
    - Full stack: overwrite the oldest entry (circular); count stays RAS_DEPTH.
    - Push and jump occur on the same edge.
  - load: out←in.
  - inc: out←(out+1) mod 2^WIDTH.
    - wrap=1 on the edge where out was all ones, 0 otherwise.
    - wrap is registered and asserted in the same cycle `out` shows 0.
  - hold: out unchanged.
- wrap and ras_err are 0 in every cycle not described above.
- Arithmetic: unsigned WIDTH-bit adds, carry discarded except as the wrap source.
- Simultaneous events:
  - load+inc: load wins.
  - call+ret: ret wins, and the call is dropped entirely (no push).
  - clr with anything: clear only.
- Reset asserted mid-operation: aborts any push/pop. The stack pointer and count return to 0; stack contents are don't-care.
- ras_full/ras_empty are derived combinationally from the registered count.

Optional Feature:
- Macro PC16_RAS_EN.
- Defined:
  - The return-address stack is instantiated.
  - call/ret behave as above.
  - ras_* outputs are live.
- Undefined:
  - No stack storage.
  - `call` behaves exactly as `load`, at call's priority position.
  - `ret` is ignored (treated as 0).
  - ras_empty tied 1, ras_full tied 0, ras_err tied 0.
  - Port list is identical in both builds.

Decomposition:
- Shared header pc16_defs.vh holds:
  - default WIDTH;
  - the action-select encodings HOLD=0, INC=1, LOAD=2, CALL=3, RET=4, CLR=5, used by the priority encoder and by the bench's reference model;
  - the reset value constant 0.
- One natural sub-module, pc16_ras:
  - circular LIFO of RAS_DEPTH×WIDTH;
  - push/pop strobes, `top` data, count, full/empty;
  - overwrite-oldest on full push;
  - compiled only under PC16_RAS_EN.

Test Plan:
- Reset/async: drive inc=1 for 5 edges (out=5), then pulse rst between edges → out=0 immediately, before the next edge; ras_empty=1.
- Increment wrap: load in=16'hFFFE, then inc for 2 edges → out=FFFF, then 0000 with wrap=1 for exactly that one cycle; next inc → 0001, wrap=0.
- Priority: in=16'h1234 with load=1, inc=1 → out=1234. Then clr=1, load=1 → out=0000. Then load=1, in=16'h0001 (upstream selector passing its a input) → out=0001.
- Call/return (PC16_RAS_EN):
  - at out=0010, call in=0100 → out=0100, ras_empty=0;
  - call in=0200 → out=0200;
  - ret → out=0101; ret → out=0011, ras_empty=1;
  - ret again → out=0011 held, ras_err pulses once.
- Stack overflow (RAS_DEPTH=4):
  - from out=0000, 5 calls targeting 1000,2000,3000,4000,5000 → ras_full=1 after the 4th;
  - 4 rets → 4001, 3001, 2001, 1001 (oldest return address 0001 overwritten);
  - 5th ret → ras_err=1.
- Macro off: call in=0ABC → out=0ABC, no push; ret → out unchanged; ras_empty=1, ras_full=0, ras_err=0 throughout.
